// File: rtl/shape_classifier.sv
// -----------------------------------------------------------------------------
// shape_classifier
//   Colour/shape detector for an RGB332 camera stream. Per frame it counts red
//   and blue pixels (whole screen) and red/blue pixels on NUM_BANDS horizontal
//   sample rows. At frame end the counts are snapshotted, the dominant colour's
//   band profile is walked one band pair per cycle, and a 3-bit result is
//   published with a one-cycle valid pulse plus a multi-frame stability flag.
//
// Ports
//   CLK            pixel clock, rising edge
//   RESET_N        asynchronous active-low reset
//   PIXEL_IN       RGB332 pixel: R[7:5] G[4:2] B[1:0]
//   PIXEL_VALID    qualifies PIXEL_IN this cycle
//   VGA_PIXEL_X/Y  coordinates of PIXEL_IN
//   VGA_VSYNC_NEG  asynchronous frame sync, falling edge marks frame end
//   RESULT         0 none, 1/2/3 blue tri/dia/sq, 4/5/6 red tri/dia/sq
//   RESULT_VALID   one-cycle pulse when RESULT updates
//   RESULT_STABLE  last STABLE_FRAMES published results were identical
// -----------------------------------------------------------------------------
module shape_classifier #(
    parameter int SCREEN_WIDTH  = 176,
    parameter int SCREEN_HEIGHT = 144,
    parameter int NUM_BANDS     = 5,
    parameter int BAND_Y0       = 42,
    parameter int BAND_PITCH    = 15,
    parameter int BAND_X_MIN    = 48,
    parameter int BAND_X_MAX    = 128,
    parameter int COLOR_THRESH  = 17000,
    parameter int STABLE_FRAMES = 3,
    parameter int CNT_W         = 16
) (
    input  logic       CLK,
    input  logic       RESET_N,
    input  logic [7:0] PIXEL_IN,
    input  logic       PIXEL_VALID,
    input  logic [9:0] VGA_PIXEL_X,
    input  logic [9:0] VGA_PIXEL_Y,
    input  logic       VGA_VSYNC_NEG,
    output logic [2:0] RESULT,
    output logic       RESULT_VALID,
    output logic       RESULT_STABLE
);

    localparam logic [CNT_W-1:0] CNT_MAX  = '1;
    localparam logic [9:0]       X_LIM    = 10'(SCREEN_WIDTH);
    localparam logic [9:0]       Y_LIM    = 10'(SCREEN_HEIGHT);
    localparam logic [9:0]       COL_LO   = 10'(BAND_X_MIN);
    localparam logic [9:0]       COL_HI   = 10'(BAND_X_MAX);
    localparam logic [2:0]       LAST_IDX = 3'(NUM_BANDS - 2);
    localparam logic [3:0]       STABLE_N = 4'(STABLE_FRAMES);

    typedef enum logic [1:0] {ACCUM, CLASSIFY, PUBLISH} state_t;

    typedef logic [CNT_W-1:0] cnt_t;

    function automatic cnt_t sat_inc(input cnt_t v, input logic en);
        return (en && v != CNT_MAX) ? v + CNT_W'(1) : v;
    endfunction

    // ---------------- frame-sync synchroniser and edge detect ----------------
    logic vs_s1, vs_s2, vs_d;
    logic fe;

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            vs_s1 <= 1'b1;
            vs_s2 <= 1'b1;
            vs_d  <= 1'b1;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
            vs_s1 <= VGA_VSYNC_NEG;
            vs_s2 <= vs_s1;
            vs_d  <= vs_s2;
        end
    end

    assign fe = vs_d & ~vs_s2;

    // ---------------- pixel classification ----------------
    logic [1:0] r2, g2, b2;
    logic       is_red, is_blue, on_screen, in_cols;
    logic [NUM_BANDS-1:0] band_hit;

    assign r2        = PIXEL_IN[7:6];
    assign g2        = PIXEL_IN[4:3];
    assign b2        = PIXEL_IN[1:0];
    assign is_red    = (r2 > b2) && (r2 > g2);
    assign is_blue   = (b2 > r2) && (b2 > g2);
    assign on_screen = PIXEL_VALID && (VGA_PIXEL_X < X_LIM) && (VGA_PIXEL_Y < Y_LIM);
    assign in_cols   = (VGA_PIXEL_X >= COL_LO) && (VGA_PIXEL_X <= COL_HI);

    for (genvar k = 0; k < NUM_BANDS; k++) begin : g_band
        localparam logic [9:0] ROW = 10'(BAND_Y0 + k * BAND_PITCH);
        assign band_hit[k] = on_screen && in_cols && (VGA_PIXEL_Y == ROW);
    end

    // ---------------- live counters ----------------
    state_t state;
    logic   frame_clr;
    cnt_t   red_tot, blue_tot;
    cnt_t   red_band  [NUM_BANDS];
    cnt_t   blue_band [NUM_BANDS];

    // Snapshot and clear happen in the same cycle; the FE-cycle pixel lands in the new frame.
    assign frame_clr = (state == ACCUM) && fe;

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            red_tot  <= '0;
            blue_tot <= '0;
            // NOTE: these arrays are plain flops, not RAM, so clearing them in reset is legal and intended.
            for (int k = 0; k < NUM_BANDS; k++) begin
                red_band[k]  <= '0;
                blue_band[k] <= '0;
            end
        end else begin
            red_tot  <= sat_inc(frame_clr ? '0 : red_tot,  on_screen && is_red);
            blue_tot <= sat_inc(frame_clr ? '0 : blue_tot, on_screen && is_blue);
            for (int k = 0; k < NUM_BANDS; k++) begin
                red_band[k]  <= sat_inc(frame_clr ? '0 : red_band[k],  band_hit[k] && is_red);
                blue_band[k] <= sat_inc(frame_clr ? '0 : blue_band[k], band_hit[k] && is_blue);
            end
        end
    end

    // ---------------- sequential comparator datapath ----------------
    cnt_t       red_snap, blue_snap;
    cnt_t       red_band_snap  [NUM_BANDS];
    cnt_t       blue_band_snap [NUM_BANDS];
    logic [2:0] idx, idx_nx;
    logic       inc_acc, dia_acc, inc_now, dia_now, blue_dom, interior_ok;
    logic       blue_frame, red_frame;
    cnt_t       lo, hi, end0, endn;
    logic [1:0] shape;
    logic [2:0] res_new;
    logic [3:0] rep_cnt, rep_nx;

    always_comb begin
        // NOTE: every always_comb output gets a default first, so no path can infer a latch.
        idx_nx      = idx + 3'd1;
        blue_dom    = blue_snap > red_snap;
        lo          = blue_dom ? blue_band_snap[idx]    : red_band_snap[idx];
        hi          = blue_dom ? blue_band_snap[idx_nx] : red_band_snap[idx_nx];
        end0        = blue_dom ? blue_band_snap[0]      : red_band_snap[0];
        endn        = blue_dom ? blue_band_snap[NUM_BANDS-1] : red_band_snap[NUM_BANDS-1];
        // Band idx+1 is interior while it is not the last band.
        interior_ok = (idx_nx <= LAST_IDX) ? ((end0 < hi) && (endn < hi)) : 1'b1;
        inc_now     = inc_acc && (hi > lo);
        dia_now     = dia_acc && interior_ok;
        shape       = inc_now ? 2'd1 : (dia_now ? 2'd2 : 2'd3);
        blue_frame  = (blue_snap > red_snap) && (int'(blue_snap) > COLOR_THRESH);
        red_frame   = (red_snap > blue_snap) && (int'(red_snap) > COLOR_THRESH);
        res_new     = 3'd0;
        if (blue_frame)
            res_new = {1'b0, shape};
        else if (red_frame)
            res_new = {1'b0, shape} + 3'd3;
        if (res_new != RESULT)
            rep_nx = 4'd1;
        else if (rep_cnt >= STABLE_N)
            rep_nx = STABLE_N;
        else
            rep_nx = rep_cnt + 4'd1;
    end

    // ---------------- control FSM with registered outputs ----------------
    // Outputs are registered on the last CLASSIFY edge, so they are presented
    // during the PUBLISH cycle, NUM_BANDS cycles after the FE cycle.
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            state         <= ACCUM;
            idx           <= '0;
            inc_acc       <= 1'b1;
            dia_acc       <= 1'b1;
            red_snap      <= '0;
            blue_snap     <= '0;
            rep_cnt       <= '0;
            RESULT        <= 3'd0;
            RESULT_VALID  <= 1'b0;
            RESULT_STABLE <= 1'b0;
            for (int k = 0; k < NUM_BANDS; k++) begin
                red_band_snap[k]  <= '0;
                blue_band_snap[k] <= '0;
            end
        end else begin
            RESULT_VALID <= 1'b0;
            case (state)
                ACCUM: begin
                    if (fe) begin
                        red_snap       <= red_tot;
                        blue_snap      <= blue_tot;
                        red_band_snap  <= red_band;
                        blue_band_snap <= blue_band;
                        idx            <= '0;
                        inc_acc        <= 1'b1;
                        dia_acc        <= 1'b1;
                        state          <= CLASSIFY;
                    end
                end
                CLASSIFY: begin
                    inc_acc <= inc_now;
                    dia_acc <= dia_now;
                    idx     <= idx_nx;
                    if (idx == LAST_IDX) begin
                        RESULT        <= res_new;
                        RESULT_VALID  <= 1'b1;
                        rep_cnt       <= rep_nx;
                        RESULT_STABLE <= (rep_nx >= STABLE_N);
                        state         <= PUBLISH;
                    end
                end
                PUBLISH: state <= ACCUM;
                default: state <= ACCUM;
            endcase
        end
    end

endmodule

// File: tb/tb_shape_classifier.sv
// -----------------------------------------------------------------------------
// tb_shape_classifier
//   Three instances share one clock: dut 0 with default parameters (full-size
//   frames), dut 1 with a reduced colour threshold (short directed frames),
//   dut 2 with 8-bit counters (saturation). Expected results are pushed to a
//   per-instance queue when a frame is closed; a monitor per instance pops and
//   compares result, stability and arrival cycle on every RESULT_VALID.
// -----------------------------------------------------------------------------
module tb_shape_classifier;

    localparam int NB = 5;
    localparam logic [7:0] RED   = 8'hE0;
    localparam logic [7:0] BLUE  = 8'h03;
    localparam logic [7:0] RB_EQ = 8'hE3;   // R=3, G=0, B=3: neither colour

    typedef struct {
        string      name;
        logic [2:0] res;
        logic       stable;
        int         cyc;
    } exp_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;

    logic [7:0] pix   [3];
    logic [9:0] vx    [3];
    logic [9:0] vy    [3];
    logic       pv    [3];
    logic       vs    [3];
    logic       rst_n [3];
    wire  [2:0] res   [3];
    wire  [2:0] rv;
    wire  [2:0] rs;

    exp_t sbq [3][$];

    shape_classifier dut_m (
        .CLK(clk), .RESET_N(rst_n[0]), .PIXEL_IN(pix[0]), .PIXEL_VALID(pv[0]),
        .VGA_PIXEL_X(vx[0]), .VGA_PIXEL_Y(vy[0]), .VGA_VSYNC_NEG(vs[0]),
        .RESULT(res[0]), .RESULT_VALID(rv[0]), .RESULT_STABLE(rs[0])
    );

    shape_classifier #(.COLOR_THRESH(170)) dut_s (
        .CLK(clk), .RESET_N(rst_n[1]), .PIXEL_IN(pix[1]), .PIXEL_VALID(pv[1]),
        .VGA_PIXEL_X(vx[1]), .VGA_PIXEL_Y(vy[1]), .VGA_VSYNC_NEG(vs[1]),
        .RESULT(res[1]), .RESULT_VALID(rv[1]), .RESULT_STABLE(rs[1])
    );

    shape_classifier #(.CNT_W(8), .COLOR_THRESH(254)) dut_c (
        .CLK(clk), .RESET_N(rst_n[2]), .PIXEL_IN(pix[2]), .PIXEL_VALID(pv[2]),
        .VGA_PIXEL_X(vx[2]), .VGA_PIXEL_Y(vy[2]), .VGA_VSYNC_NEG(vs[2]),
        .RESULT(res[2]), .RESULT_VALID(rv[2]), .RESULT_STABLE(rs[2])
    );

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Monitors: one per instance, decoupled from stimulus.
    for (genvar g = 0; g < 3; g++) begin : g_mon
        always @(negedge clk) begin
            exp_t e;
            if (rv[g]) begin
                if (sbq[g].size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_pulse dut%0d: RESULT_VALID=1 got result %0d, expected no pulse", g, res[g]);
                end else begin
                    e = sbq[g].pop_front();
                    check({e.name, "_result"}, int'(res[g]), int'(e.res));
                    check({e.name, "_stable"}, int'(rs[g]), int'(e.stable));
                    check({e.name, "_latency_cycle"}, cyc, e.cyc);
                end
            end
        end
    end

    function automatic int row(input int k);
        return 42 + 15 * k;
    endfunction

    task automatic send(input int d, input logic [7:0] p, input int x, input int y,
                        input int n, input logic v = 1'b1);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            pix[d] = p;
            vx[d]  = 10'(x);
            vy[d]  = 10'(y);
            pv[d]  = v;
        end
        @(negedge clk);
        pv[d] = 1'b0;
    endtask

    task automatic wait_drain(input int d);
        int n;
        n = 0;
        while (sbq[d].size() != 0 && n < 40) begin
            @(negedge clk);
            n++;
        end
        if (sbq[d].size() != 0) begin
            checks++;
            errors++;
            $display("FAIL timeout dut%0d: %0d results still pending, expected 0", d, sbq[d].size());
            sbq[d].delete();
        end
    endtask

    // Drops vsync; the 2-flop synchroniser puts FE two edges later and the
    // pulse follows NB cycles after that. dbl adds a second falling edge
    // two cycles after the first, which must be ignored.
    task automatic end_frame(input int d, input string name, input logic [2:0] er,
                             input logic es, input bit dbl = 1'b0);
        exp_t e;
        @(negedge clk);
        e.name   = name;
        e.res    = er;
        e.stable = es;
        e.cyc    = cyc + 2 + NB;
        sbq[d].push_back(e);
        vs[d] = 1'b0;
        if (dbl) begin
            @(negedge clk) vs[d] = 1'b1;
            @(negedge clk) vs[d] = 1'b0;
        end
        repeat (3) @(negedge clk);
        vs[d] = 1'b1;
        wait_drain(d);
        repeat (12) @(negedge clk);
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog");
    end

    int b_tri [NB] = '{10, 20, 30, 40, 50};
    int b_dia [NB] = '{10, 40, 60, 40, 10};
    int b_sq  [NB] = '{10, 40, 60, 40, 40};

    initial begin
        for (int d = 0; d < 3; d++) begin
            pix[d] = '0; vx[d] = '0; vy[d] = '0; pv[d] = 1'b0;
            vs[d] = 1'b1; rst_n[d] = 1'b0;
        end
        repeat (3) @(negedge clk);
        for (int d = 0; d < 3; d++) rst_n[d] = 1'b1;
        @(negedge clk);
        for (int d = 0; d < 3; d++) begin
            check($sformatf("reset_result_dut%0d", d), int'(res[d]), 0);
            check($sformatf("reset_valid_dut%0d", d), int'(rv[d]), 0);
            check($sformatf("reset_stable_dut%0d", d), int'(rs[d]), 0);
        end

        // Full 176x144 all-blue frame: 25344 total, every band 81 -> blue square.
        for (int y = 0; y < 144; y++) begin
            for (int x = 0; x < 176; x++) begin
                @(negedge clk);
                pix[0] = BLUE; vx[0] = 10'(x); vy[0] = 10'(y); pv[0] = 1'b1;
            end
        end
        @(negedge clk);
        pv[0] = 1'b0;
        end_frame(0, "full_blue", 3'b011, 1'b0);

        // Red total exactly at the threshold -> none.
        send(0, RED, 0, 0, 17000);
        end_frame(0, "red_at_thresh", 3'b000, 1'b0);

        // 8-bit counters: 300 red pixels saturate at 255 > 254 -> red square.
        send(2, RED, 0, 0, 300);
        end_frame(2, "sat_cnt8", 3'b110, 1'b0);

        // Stability run: three identical blue squares.
        for (int i = 0; i < 3; i++) begin
            send(1, BLUE, 0, 0, 200);
            end_frame(1, $sformatf("stable_run%0d", i), 3'b011, (i == 2));
        end

        // Blue triangle: bands 10..50 plus 50 off-band, total 200.
        for (int k = 0; k < NB; k++) send(1, BLUE, 100, row(k), b_tri[k]);
        send(1, BLUE, 0, 0, 50);
        end_frame(1, "blue_triangle", 3'b001, 1'b0);

        // Red diamond at inclusive column edges; pixels just outside the
        // column window on band 0 must not count toward the band.
        for (int k = 0; k < NB; k++) send(1, RED, (k == 2) ? 128 : 48, row(k), b_dia[k]);
        send(1, RED, 47, row(0), 30);
        send(1, RED, 129, row(0), 30);
        end_frame(1, "red_diamond", 3'b101, 1'b0);

        // Last band no longer below the interior -> red square.
        for (int k = 0; k < NB; k++) send(1, RED, 60, row(k), b_sq[k]);
        end_frame(1, "red_square", 3'b110, 1'b0);

        // Equal totals; invalid and neutral pixels must not tip the balance.
        send(1, RED, 0, 0, 180);
        send(1, BLUE, 0, 0, 180);
        send(1, RED, 0, 0, 20, 1'b0);
        send(1, RB_EQ, 0, 0, 20);
        end_frame(1, "equal_totals", 3'b000, 1'b0);

        // At threshold with off-screen pixels ignored -> none (repeat of 000).
        send(1, RED, 0, 0, 170);
        send(1, RED, 176, 0, 10);
        send(1, RED, 0, 144, 10);
        end_frame(1, "thresh_edge", 3'b000, 1'b0);

        // One above threshold, with a second FE two cycles after the first.
        send(1, RED, 0, 0, 171);
        end_frame(1, "double_fe", 3'b110, 1'b0, 1'b1);

        // Reset mid-frame discards the partial blue frame.
        send(1, BLUE, 0, 0, 100);
        @(negedge clk) rst_n[1] = 1'b0;
        @(negedge clk);
        check("midreset_result", int'(res[1]), 0);
        check("midreset_valid", int'(rv[1]), 0);
        check("midreset_stable", int'(rs[1]), 0);
        @(negedge clk) rst_n[1] = 1'b1;
        send(1, RED, 0, 0, 200);
        end_frame(1, "after_reset", 3'b110, 1'b0);

        repeat (10) @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
